pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/forward controller for the 5-stage 64-bit RISC-V pipeline. It drives the enable (stall) and clear (flush) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and generates EX-stage forwarding selects. It also runs a data-memory wait FSM with a timeout fault, and keeps saturating performance counters for stall and flush cycles.

Parameters:
TIMEOUT, 16, max consecutive memory-wait cycles before fault (≥2)
CNT_W, 32, width of performance counters

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
Rs1D  input  5  rs1 of instruction in ID
Rs2D  input  5  rs2 of instruction in ID
Rs1E  input  5  rs1 of instruction in EX
Rs2E  input  5  rs2 of instruction in EX
RD_E  input  5  destination reg in EX
MemToRegE  input  1  EX instruction is a load
PCSrcE  input  1  branch/jump taken, resolved in EX
RegWriteM  input  1  MEM instruction writes RF
RD_M  input  5  destination reg in MEM
MemReqM  input  1  MEM stage accesses data memory
DMemReady  input  1  data memory completes access this cycle
RegWriteW  input  1  WB instruction writes RF
RD_W  input  5  destination reg in WB
StallF  output  1  hold PC
StallD  output  1  hold IF/ID
StallE  output  1  hold ID/EX
StallM  output  1  hold EX/MEM
FlushD  output  1  clear IF/ID
FlushE  output  1  clear ID/EX
BubbleW  output  1  load zeros into MEM/WB (kills RegWrite)
ForwardAE  output  2  ALU operand A select: 00 RF, 01 WB result, 10 MEM ALU result
ForwardBE  output  2  same for operand B
MemFault  output  1  sticky memory-timeout fault
StallCount  output  CNT_W  cycles with StallF=1
FlushCount  output  CNT_W  cycles with FlushE=1

Behaviour:
- Stall/flush/forward outputs are combinational from inputs and state. Counters, state and MemFault are registered.
- While reset=1: all Stall*=0, FlushD=FlushE=1, BubbleW=1, Forward*=00. Asynchronously: state=RUN, wait counter=0, MemFault=0, StallCount=FlushCount=0.
- memwait = MemReqM & ~DMemReady.
- FSM states:
  - RUN→WAIT when memwait.
  - WAIT→RUN when DMemReady.
  - WAIT→FAULT when the wait counter reaches TIMEOUT-1 with memwait still high.
  - FAULT holds until reset.
- Wait counter: cleared in RUN, increments each WAIT cycle.
- Priority 1 (memory): memwait in RUN or WAIT, or state FAULT → StallF=StallD=StallE=StallM=1, BubbleW=1, FlushD=FlushE=0. PCSrcE and load-use are ignored (EX is frozen, so they are re-evaluated after release). MemFault=1 in FAULT.
- Release: the cycle DMemReady=1, memwait=0, so all stalls drop in that same cycle and the data is captured into MEM/WB. Zero-wait accesses never leave RUN.
- Priority 2 (branch): PCSrcE → FlushD=FlushE=1, no stalls. Overrides load-use, because the dependent instruction is being flushed.
- Priority 3 (load-use): MemToRegE & RD_E≠0 & (RD_E==Rs1D | RD_E==Rs2D) → StallF=StallD=1, FlushE=1. Exactly one bubble per load-use.
- Forwarding, per operand X∈{A,B} with source RsXE:
  - 10 if RegWriteM & RD_M≠0 & RD_M==RsXE;
  - else 01 if RegWriteW & RD_W≠0 & RD_W==RsXE;
  - else 00.
  - MEM beats WB when both match. x0 is never forwarded.
- Counters: increment when the corresponding output is 1 and reset=0. Saturate at all-ones (no wrap).
- Reset mid-wait: state returns to RUN immediately; the outstanding request is abandoned.

Test Plan:
- Load-use: MemToRegE=1, RD_E=5, Rs1D=5, PCSrcE=0, MemReqM=0 → StallF=StallD=FlushE=1, FlushD=0, BubbleW=0; StallCount 0→1 after one edge.
- x0 load: same stimulus with RD_E=0 → no stall, no flush.
- Branch + load-use simultaneous: PCSrcE=1, load-use match → FlushD=FlushE=1, StallF=0; FlushCount increments by 1.
- Forwarding: RegWriteM=1, RD_M=7, RegWriteW=1, RD_W=7, Rs1E=7, Rs2E=7 → ForwardAE=ForwardBE=10. Set RegWriteM=0 → 01. Set RD_W=0 → 00.
- Memory wait: MemReqM=1, DMemReady=0 for 3 cycles, then 1 (TIMEOUT=16) → all stalls and BubbleW=1 for 3 cycles, 0 in the ready cycle; state back to RUN; MemFault=0; StallCount=3.
- Timeout: MemReqM=1, DMemReady=0 held for 16 cycles (TIMEOUT=16) → FAULT entered, MemFault=1 and all stalls held even after DMemReady=1. Async reset pulse mid-cycle → MemFault=0, counters 0, FlushD=FlushE=1 while reset is high.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for a 5-stage 64-bit RISC-V pipeline, with a
// data-memory wait FSM, timeout fault and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RD_E,
    input  logic             MemToRegE,
    input  logic             PCSrcE,
    input  logic             RegWriteM,
    input  logic [4:0]       RD_M,
    input  logic             MemReqM,
    input  logic             DMemReady,
    input  logic             RegWriteW,
    input  logic [4:0]       RD_W,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             BubbleW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemFault,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_FAULT
    } state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic memwait;
    logic mem_hold;
    logic load_use;

    // Forward from the youngest producer; x0 is hardwired zero so never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign memwait  = MemReqM & ~DMemReady;
    assign mem_hold = memwait | (state_q == ST_FAULT);
    assign load_use = MemToRegE && (RD_E != 5'd0) && ((RD_E == Rs1D) || (RD_E == Rs2D));
    assign MemFault = (state_q == ST_FAULT);

    // wait_cnt counts consecutive memwait cycles, so the fault fires after TIMEOUT of them.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d    = state_q;
        wait_cnt_d = '0;
        unique case (state_q)
            ST_RUN: begin
                if (memwait) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!memwait) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        BubbleW   = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (reset) begin
            FlushD  = 1'b1;
            FlushE  = 1'b1;
            BubbleW = 1'b1;
        end else begin
            ForwardAE = fwd_sel(Rs1E, RegWriteM, RD_M, RegWriteW, RD_W);
            ForwardBE = fwd_sel(Rs2E, RegWriteM, RD_M, RegWriteW, RD_W);
            // EX is frozen under a memory hold, so branch and load-use are re-evaluated on release.
            if (mem_hold) begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                StallM  = 1'b1;
                BubbleW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (FlushE && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (TIMEOUT=16, CNT_W=32).
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    logic             clk;
    logic             reset;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RD_E, RD_M, RD_W;
    logic             MemToRegE, PCSrcE, RegWriteM, MemReqM, DMemReady, RegWriteW;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW, MemFault;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int checks;
    int errors;

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RD_E       (RD_E),
        .MemToRegE  (MemToRegE),
        .PCSrcE     (PCSrcE),
        .RegWriteM  (RegWriteM),
        .RD_M       (RD_M),
        .MemReqM    (MemReqM),
        .DMemReady  (DMemReady),
        .RegWriteW  (RegWriteW),
        .RD_W       (RD_W),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .BubbleW    (BubbleW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MemFault   (MemFault),
        .StallCount (StallCount),
        .FlushCount (FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want normal end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
        MemToRegE = 0; PCSrcE = 0; RegWriteM = 0; MemReqM = 0; DMemReady = 0; RegWriteW = 0;
    endtask

    task automatic check_mem_hold(input string tag);
        check({tag, "_stallF"}, StallF, 1);
        check({tag, "_stallM"}, StallM, 1);
        check({tag, "_stallE"}, StallE, 1);
        check({tag, "_bubbleW"}, BubbleW, 1);
        check({tag, "_flushE"}, FlushE, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        reset = 1'b1;
        // Forwarding match present during reset must still yield 00.
        RegWriteM = 1; RD_M = 7; Rs1E = 7;
        #2;
        check("rst_stallF", StallF, 0);
        check("rst_flushD", FlushD, 1);
        check("rst_flushE", FlushE, 1);
        check("rst_bubbleW", BubbleW, 1);
        check("rst_fwdA", ForwardAE, 2'b00);
        check("rst_memfault", MemFault, 0);
        check("rst_stallcnt", StallCount, 0);
        step();
        step();
        reset = 1'b0;
        clear_inputs();

        // Load-use
        MemToRegE = 1; RD_E = 5; Rs1D = 5;
        #1;
        check("lu_stallF", StallF, 1);
        check("lu_stallD", StallD, 1);
        check("lu_stallE", StallE, 0);
        check("lu_flushE", FlushE, 1);
        check("lu_flushD", FlushD, 0);
        check("lu_bubbleW", BubbleW, 0);
        check("lu_stallcnt0", StallCount, 0);
        step();
        check("lu_stallcnt1", StallCount, 1);
        check("lu_flushcnt1", FlushCount, 1);

        // Load into x0: no hazard
        RD_E = 0; Rs1D = 0;
        #1;
        check("x0_stallF", StallF, 0);
        check("x0_flushE", FlushE, 0);
        step();
        check("x0_stallcnt", StallCount, 1);

        // Branch overrides load-use (match on rs2)
        RD_E = 9; Rs2D = 9; PCSrcE = 1;
        #1;
        check("br_flushD", FlushD, 1);
        check("br_flushE", FlushE, 1);
        check("br_stallF", StallF, 0);
        step();
        check("br_flushcnt", FlushCount, 2);
        check("br_stallcnt", StallCount, 1);
        clear_inputs();

        // Forwarding priority and x0
        RegWriteM = 1; RD_M = 7; RegWriteW = 1; RD_W = 7; Rs1E = 7; Rs2E = 7;
        #1;
        check("fw_memA", ForwardAE, 2'b10);
        check("fw_memB", ForwardBE, 2'b10);
        RegWriteM = 0;
        #1;
        check("fw_wbA", ForwardAE, 2'b01);
        check("fw_wbB", ForwardBE, 2'b01);
        RD_W = 0;
        #1;
        check("fw_noneA", ForwardAE, 2'b00);
        check("fw_noneB", ForwardBE, 2'b00);
        RegWriteM = 1; RD_M = 3; RegWriteW = 1; RD_W = 12; Rs1E = 12; Rs2E = 3;
        #1;
        check("fw_splitA", ForwardAE, 2'b01);
        check("fw_splitB", ForwardBE, 2'b10);
        RD_M = 0; Rs1E = 0; Rs2E = 0; RD_W = 0;
        #1;
        check("fw_x0A", ForwardAE, 2'b00);
        check("fw_x0B", ForwardBE, 2'b00);
        clear_inputs();
        step();

        // Memory wait: 3 wait cycles then ready
        MemReqM = 1; DMemReady = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (i == 1) PCSrcE = 1;
            #1;
            check_mem_hold($sformatf("mw%0d", i));
            check("mw_flushD", FlushD, 0);
            step();
            PCSrcE = 0;
        end
        DMemReady = 1;
        #1;
        check("mw_rdy_stallF", StallF, 0);
        check("mw_rdy_bubbleW", BubbleW, 0);
        check("mw_rdy_memfault", MemFault, 0);
        step();
        check("mw_stallcnt", StallCount, 4);
        check("mw_flushcnt", FlushCount, 2);
        // Zero-wait access right after: FSM must be back in RUN
        #1;
        check("zw_stallF", StallF, 0);
        step();

        // Timeout: 16 consecutive memwait cycles enter FAULT
        DMemReady = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            check($sformatf("to_nofault%0d", i), MemFault, 0);
            step();
        end
        check("to_memfault", MemFault, 1);
        check_mem_hold("to");
        DMemReady = 1; MemReqM = 0;
        #1;
        check_mem_hold("fault_rdy");
        check("fault_sticky", MemFault, 1);
        step();
        step();
        check("to_stallcnt", StallCount, 22);
        check("to_flushcnt", FlushCount, 2);

        // Async reset pulse between edges
        #2;
        reset = 1'b1;
        #1;
        check("ar_memfault", MemFault, 0);
        check("ar_stallcnt", StallCount, 0);
        check("ar_flushcnt", FlushCount, 0);
        check("ar_flushD", FlushD, 1);
        check("ar_flushE", FlushE, 1);
        check("ar_stallF", StallF, 0);
        reset = 1'b0;
        clear_inputs();
        #1;
        check("post_stallF", StallF, 0);
        check("post_flushE", FlushE, 0);
        step();
        check("post_stallcnt", StallCount, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
